// File: rtl/mips_multicycle_ctrl_if.sv
// ----------------------------------------------------------------------------
// mips_multicycle_ctrl_if
//   Bundles the signals between the multicycle MIPS control FSM and its
//   datapath.
//   master : the controller. It reads op/funct/zero and drives every control.
//   slave  : the datapath. It supplies op/funct/zero and consumes the controls.
//   Signals:
//     op, funct   instruction fields held in IR
//     zero        ALU result == 0
//     pcen        PC load enable
//     memwrite    data memory write strobe
//     irwrite     IR load enable
//     regwrite    register file write enable
//     iord        memory address select (PC / ALUOut)
//     memtoreg    writeback data select (ALUOut / MDR)
//     regdst      writeback register select (rt / rd)
//     alusrca     ALU A select (PC / rs)
//     alusrcb     ALU B select (rt, 4, imm, imm<<2)
//     pcsrc       next PC select (ALU, ALUOut, jump target)
//     alusel      ALU operation code
//     illegal_op  unsupported op/funct seen in DECODE
//     state       current FSM state, for debug
// ----------------------------------------------------------------------------
interface mips_multicycle_ctrl_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       pcen;
   logic       memwrite;
   logic       irwrite;
   logic       regwrite;
   logic       iord;
   logic       memtoreg;
   logic       regdst;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic [2:0] alusel;
   logic       illegal_op;
   logic [3:0] state;

   modport master (
      input  op, funct, zero,
      output pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
             alusrca, alusrcb, pcsrc, alusel, illegal_op, state
   );

   modport slave (
      output op, funct, zero,
      input  pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
             alusrca, alusrcb, pcsrc, alusel, illegal_op, state
   );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Main control FSM for the multicycle MIPS core: fetch, decode, execute,
//   memory access and writeback.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    master side of mips_multicycle_ctrl_if (op/funct/zero in,
//            all datapath controls, illegal_op and state out)
//   Parameters:
//     ENABLE_ADDI  decode ADDI (op 08h); otherwise it is illegal
//     ENABLE_J     decode J (op 02h); otherwise it is illegal
// ----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
   parameter bit ENABLE_ADDI = 1'b1,
   parameter bit ENABLE_J    = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   mips_multicycle_ctrl_if.master bus
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11
   } state_t;

   // Control word held for the current state. pcwrite/branch are internal:
   // they combine with zero to form pcen.
   typedef struct packed {
      logic       memwrite;
      logic       irwrite;
      logic       regwrite;
      logic       iord;
      logic       memtoreg;
      logic       regdst;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [2:0] alusel;
      logic       pcwrite;
      logic       branch;
   } ctrl_t;

   // Returns {valid, alusel} for an R-type funct field.
   function automatic logic [3:0] funct_decode(input logic [5:0] fn);
      logic [3:0] r;
      case (fn)
         6'h20:   r = {1'b1, 3'd2};   // add
         6'h22:   r = {1'b1, 3'd6};   // sub
         6'h24:   r = {1'b1, 3'd0};   // and
         6'h25:   r = {1'b1, 3'd1};   // or
         6'h2A:   r = {1'b1, 3'd7};   // slt
         default: r = 4'b0000;
      endcase
      return r;
   endfunction

   // Moore decode of a state into its control word. The funct field only
   // matters for EXECUTE. It is sampled while leaving DECODE, where IR is
   // already stable.
   function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] fn);
      ctrl_t      c;
      logic [3:0] fd;
      c  = '0;
      fd = funct_decode(fn);
      case (s)
         FETCH:   begin c.irwrite = 1'b1; c.alusrcb = 2'd1; c.alusel = 3'd2; c.pcwrite = 1'b1; end
         DECODE:  begin c.alusrcb = 2'd3; c.alusel = 3'd2; end
         MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'd2; c.alusel = 3'd2; end
         MEMRD:   begin c.iord = 1'b1; end
         MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
         MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
         EXECUTE: begin c.alusrca = 1'b1; c.alusel = fd[2:0]; end
         ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
         BRANCH:  begin c.alusrca = 1'b1; c.alusel = 3'd6; c.pcsrc = 2'd1; c.branch = 1'b1; end
         ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'd2; c.alusel = 3'd2; end
         ADDIWB:  begin c.regwrite = 1'b1; end
         JUMP:    begin c.pcsrc = 2'd2; c.pcwrite = 1'b1; end
         default: ;
      endcase
      return c;
   endfunction

   state_t     state_q;
   state_t     state_d;
   ctrl_t      ctrl_q;
   logic       started_q;
   logic       decode_ok;
   logic [3:0] funct_info;

   // NOTE: every variable assigned in this block gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d    = FETCH;
      decode_ok  = 1'b1;
      funct_info = funct_decode(bus.funct);
      case (state_q)
         FETCH: state_d = DECODE;
         DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE: begin
                  if (funct_info[3]) state_d = EXECUTE;
                  else               decode_ok = 1'b0;
               end
               OP_BEQ: state_d = BRANCH;
               OP_ADDI: begin
                  if (ENABLE_ADDI) state_d = ADDIEX;
                  else             decode_ok = 1'b0;
               end
               OP_J: begin
                  if (ENABLE_J) state_d = JUMP;
                  else          decode_ok = 1'b0;
               end
               default: decode_ok = 1'b0;
            endcase
         end
         MEMADR:  state_d = (bus.op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:   state_d = MEMWB;
         EXECUTE: state_d = ALUWB;
         ADDIEX:  state_d = ADDIWB;
         default: state_d = FETCH;   // write-back states, and codes 12-15
      endcase
   end

   // The first edge after reset release only arms the FETCH outputs, so that
   // the instruction fetch gets a full cycle with pcen/irwrite asserted.
   // NOTE: state is updated with non-blocking assignments so every flop
   // samples values from before the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= FETCH;
         started_q <= 1'b0;
         ctrl_q    <= '0;
      end else if (!started_q) begin
         started_q <= 1'b1;
         state_q   <= FETCH;
         ctrl_q    <= ctrl_for(FETCH, bus.funct);
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_for(state_d, bus.funct);
      end
   end

   // illegal_op depends on op during DECODE. IR is only loaded at the edge
   // that enters DECODE, so the flag cannot be registered ahead of time.
   assign bus.illegal_op = (state_q == DECODE) && !decode_ok;
   assign bus.pcen       = ctrl_q.pcwrite | (ctrl_q.branch & bus.zero);
   assign bus.memwrite   = ctrl_q.memwrite;
   assign bus.irwrite    = ctrl_q.irwrite;
   assign bus.regwrite   = ctrl_q.regwrite;
   assign bus.iord       = ctrl_q.iord;
   assign bus.memtoreg   = ctrl_q.memtoreg;
   assign bus.regdst     = ctrl_q.regdst;
   assign bus.alusrca    = ctrl_q.alusrca;
   assign bus.alusrcb    = ctrl_q.alusrcb;
   assign bus.pcsrc      = ctrl_q.pcsrc;
   assign bus.alusel     = ctrl_q.alusel;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//   Self-checking bench for mips_multicycle_ctrl. It runs two instances:
//   dut with ADDI and J enabled, and dut_nj with both disabled.
//   A behavioural model expands each decoded instruction into its list of
//   steps and checks every output on every falling edge. Directed sequences
//   pin the model with literal values, then a randomized phase follows.
// ----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mips_multicycle_ctrl_if bus0 ();
   mips_multicycle_ctrl_if bus1 ();

   mips_multicycle_ctrl #(.ENABLE_ADDI(1'b1), .ENABLE_J(1'b1)) dut (
      .clk(clk), .reset(reset), .bus(bus0)
   );
   mips_multicycle_ctrl #(.ENABLE_ADDI(1'b0), .ENABLE_J(1'b0)) dut_nj (
      .clk(clk), .reset(reset), .bus(bus1)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Packed output bundle:
   // {state, pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
   //  alusrca, alusrcb, pcsrc, alusel, illegal_op}
   logic [19:0] act0, act1;
   assign act0 = {bus0.state, bus0.pcen, bus0.memwrite, bus0.irwrite, bus0.regwrite,
                  bus0.iord, bus0.memtoreg, bus0.regdst, bus0.alusrca, bus0.alusrcb,
                  bus0.pcsrc, bus0.alusel, bus0.illegal_op};
   assign act1 = {bus1.state, bus1.pcen, bus1.memwrite, bus1.irwrite, bus1.regwrite,
                  bus1.iord, bus1.memtoreg, bus1.regdst, bus1.alusrca, bus1.alusrcb,
                  bus1.pcsrc, bus1.alusel, bus1.illegal_op};

   // ---------------- behavioural model ----------------
   typedef enum int {
      K_FETCH, K_DECODE, K_MEMADR, K_MEMRD, K_MEMWB, K_MEMWR,
      K_EXEC, K_ALUWB, K_BRANCH, K_ADDIEX, K_ADDIWB, K_JUMP
   } kind_t;

   kind_t      seq [2][4];
   int         len [2];
   int         pos [2];
   logic       dead [2] = '{1'b1, 1'b1};
   logic [2:0] m_alu [2];

   function automatic logic [19:0] expect_bundle(input kind_t k, input logic [2:0] alu,
                                                 input logic z, input logic ill);
      logic [3:0] st;
      logic       pcen, mw, irw, rw, iord, m2r, rd, asa;
      logic [1:0] asb, psrc;
      logic [2:0] as;
      {st, pcen, mw, irw, rw, iord, m2r, rd, asa, asb, psrc, as} = '0;
      case (k)
         K_FETCH:  begin st = 4'd0;  irw = 1'b1; asb = 2'd1; as = 3'd2; pcen = 1'b1; end
         K_DECODE: begin st = 4'd1;  asb = 2'd3; as = 3'd2; end
         K_MEMADR: begin st = 4'd2;  asa = 1'b1; asb = 2'd2; as = 3'd2; end
         K_MEMRD:  begin st = 4'd3;  iord = 1'b1; end
         K_MEMWB:  begin st = 4'd4;  m2r = 1'b1; rw = 1'b1; end
         K_MEMWR:  begin st = 4'd5;  iord = 1'b1; mw = 1'b1; end
         K_EXEC:   begin st = 4'd6;  asa = 1'b1; as = alu; end
         K_ALUWB:  begin st = 4'd7;  rd = 1'b1; rw = 1'b1; end
         K_BRANCH: begin st = 4'd8;  asa = 1'b1; as = 3'd6; psrc = 2'd1; pcen = z; end
         K_ADDIEX: begin st = 4'd9;  asa = 1'b1; asb = 2'd2; as = 3'd2; end
         K_ADDIWB: begin st = 4'd10; rw = 1'b1; end
         K_JUMP:   begin st = 4'd11; psrc = 2'd2; pcen = 1'b1; end
         default:  ;
      endcase
      return {st, pcen, mw, irw, rw, iord, m2r, rd, asa, asb, psrc, as, ill};
   endfunction

   task automatic restart(input int d);
      seq[d][0] = K_FETCH;
      seq[d][1] = K_DECODE;
      len[d]    = 2;
      pos[d]    = 0;
   endtask

   // Instance d: 0 = full decoder, 1 = ADDI and J disabled.
   task automatic model_step(input int d, input logic rst, input logic [5:0] op,
                             input logic [5:0] funct, input logic z, input logic [19:0] act);
      kind_t      k;
      logic       ill;
      logic [2:0] alu;
      int         n;
      ill = 1'b0;
      alu = 3'd0;
      n   = 0;
      if (rst) begin
         dead[d] = 1'b1;
         check($sformatf("dut%0d in reset", d), 32'(act), 32'd0);
         return;
      end
      if (dead[d]) begin
         dead[d] = 1'b0;
         restart(d);
         check($sformatf("dut%0d idle after release", d), 32'(act), 32'd0);
         return;
      end
      k = seq[d][pos[d]];
      pos[d]++;
      if (k == K_DECODE) begin
         case (op)
            6'h23: begin seq[d][0] = K_MEMADR; seq[d][1] = K_MEMRD; seq[d][2] = K_MEMWB; n = 3; end
            6'h2B: begin seq[d][0] = K_MEMADR; seq[d][1] = K_MEMWR; n = 2; end
            6'h00: begin
               case (funct)
                  6'h20: alu = 3'd2;
                  6'h22: alu = 3'd6;
                  6'h24: alu = 3'd0;
                  6'h25: alu = 3'd1;
                  6'h2A: alu = 3'd7;
                  default: ill = 1'b1;
               endcase
               if (!ill) begin seq[d][0] = K_EXEC; seq[d][1] = K_ALUWB; n = 2; end
            end
            6'h04: begin seq[d][0] = K_BRANCH; n = 1; end
            6'h08: begin
               if (d == 0) begin seq[d][0] = K_ADDIEX; seq[d][1] = K_ADDIWB; n = 2; end
               else ill = 1'b1;
            end
            6'h02: begin
               if (d == 0) begin seq[d][0] = K_JUMP; n = 1; end
               else ill = 1'b1;
            end
            default: ill = 1'b1;
         endcase
         m_alu[d] = alu;
         len[d]   = n;
         pos[d]   = 0;
      end
      if (k == K_EXEC) alu = m_alu[d];
      check($sformatf("dut%0d step %0d", d, int'(k)), 32'(act), 32'(expect_bundle(k, alu, z, ill)));
      if (pos[d] >= len[d]) restart(d);
   endtask

   // Single compare process for both instances.
   always @(negedge clk) begin
      model_step(0, reset, bus0.op, bus0.funct, bus0.zero, act0);
      model_step(1, reset, bus1.op, bus1.funct, bus1.zero, act1);
   end

   // ---------------- stimulus ----------------
   task automatic expect_state(input string name, input logic [3:0] s);
      @(negedge clk);
      check(name, 32'(bus0.state), 32'(s));
   endtask

   function automatic logic [5:0] pick_op();
      case ($urandom_range(0, 7))
         0: return 6'h00;
         1: return 6'h23;
         2: return 6'h2B;
         3: return 6'h04;
         4: return 6'h08;
         5: return 6'h02;
         6: return 6'($urandom);
         default: return 6'h00;
      endcase
   endfunction

   function automatic logic [5:0] pick_funct();
      case ($urandom_range(0, 5))
         0: return 6'h20;
         1: return 6'h22;
         2: return 6'h24;
         3: return 6'h25;
         4: return 6'h2A;
         default: return 6'($urandom);
      endcase
   endfunction

   initial begin
      reset = 1'b1;
      bus0.op = 6'h00; bus0.funct = 6'h22; bus0.zero = 1'b0;
      bus1.op = 6'h02; bus1.funct = 6'h00; bus1.zero = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;

      // Idle half-cycle after release, then R-type SUB: 0,1,6,7,0
      @(negedge clk);
      check("post-release irwrite", 32'(bus0.irwrite), 32'd0);
      expect_state("sub fetch", 4'd0);
      check("fetch pcen", 32'(bus0.pcen), 32'd1);
      check("fetch irwrite", 32'(bus0.irwrite), 32'd1);
      check("nj fetch", 32'(bus1.state), 32'd0);
      expect_state("sub decode", 4'd1);
      check("sub no illegal", 32'(bus0.illegal_op), 32'd0);
      check("nj J illegal", 32'(bus1.illegal_op), 32'd1);
      check("nj decode", 32'(bus1.state), 32'd1);
      expect_state("sub execute", 4'd6);
      check("sub alusel", 32'(bus0.alusel), 32'd6);
      check("sub exec no regwrite", 32'(bus0.regwrite), 32'd0);
      check("nj back to fetch", 32'(bus1.state), 32'd0);
      expect_state("sub aluwb", 4'd7);
      check("sub regwrite", 32'(bus0.regwrite), 32'd1);
      check("sub regdst", 32'(bus0.regdst), 32'd1);
      expect_state("sub done", 4'd0);
      #1 bus0.op = 6'h23;

      // LW: 1,2,3,4,0
      expect_state("lw decode", 4'd1);
      expect_state("lw memadr", 4'd2);
      expect_state("lw memrd", 4'd3);
      check("lw iord", 32'(bus0.iord), 32'd1);
      expect_state("lw memwb", 4'd4);
      check("lw memtoreg", 32'(bus0.memtoreg), 32'd1);
      check("lw regwrite", 32'(bus0.regwrite), 32'd1);
      expect_state("lw done", 4'd0);
      #1 begin bus0.op = 6'h04; bus0.zero = 1'b1; end

      // BEQ taken, then not taken
      expect_state("beq1 decode", 4'd1);
      expect_state("beq1 branch", 4'd8);
      check("beq taken pcen", 32'(bus0.pcen), 32'd1);
      check("beq pcsrc", 32'(bus0.pcsrc), 32'd1);
      expect_state("beq1 done", 4'd0);
      #1 bus0.zero = 1'b0;
      expect_state("beq2 decode", 4'd1);
      expect_state("beq2 branch", 4'd8);
      check("beq not taken pcen", 32'(bus0.pcen), 32'd0);
      expect_state("beq2 done", 4'd0);
      #1 bus0.op = 6'h3F;

      // Illegal op: 1 (pulse), 0
      expect_state("ill decode", 4'd1);
      check("ill pulse", 32'(bus0.illegal_op), 32'd1);
      check("ill no write", 32'({bus0.regwrite, bus0.memwrite, bus0.irwrite, bus0.pcen}), 32'd0);
      expect_state("ill back", 4'd0);
      check("ill pulse ends", 32'(bus0.illegal_op), 32'd0);
      #1 bus0.op = 6'h02;

      // J enabled: 1,11,0
      expect_state("j decode", 4'd1);
      expect_state("j jump", 4'd11);
      check("j pcsrc", 32'(bus0.pcsrc), 32'd2);
      check("j pcen", 32'(bus0.pcen), 32'd1);
      expect_state("j done", 4'd0);
      #1 bus0.op = 6'h08;

      // ADDI: 1,9,10,0
      expect_state("addi decode", 4'd1);
      expect_state("addi ex", 4'd9);
      expect_state("addi wb", 4'd10);
      check("addi regwrite", 32'(bus0.regwrite), 32'd1);
      check("addi regdst", 32'(bus0.regdst), 32'd0);
      expect_state("addi done", 4'd0);
      #1 bus0.op = 6'h2B;

      // SW interrupted by reset inside MEMWR
      expect_state("sw decode", 4'd1);
      expect_state("sw memadr", 4'd2);
      expect_state("sw memwr", 4'd5);
      check("sw memwrite", 32'(bus0.memwrite), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("reset abort state", 32'(bus0.state), 32'd0);
      check("reset abort memwrite", 32'(bus0.memwrite), 32'd0);
      @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      check("re-release idle irwrite", 32'(bus0.irwrite), 32'd0);
      expect_state("re-fetch", 4'd0);
      check("re-fetch pcen", 32'(bus0.pcen), 32'd1);
      check("re-fetch irwrite", 32'(bus0.irwrite), 32'd1);
      expect_state("re-decode", 4'd1);

      // Randomized phase. op/funct are scrambled in states that must ignore them.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk);
         #1;
         if ($urandom_range(0, 299) == 0) begin
            reset = 1'b1;
            #1;
            check("rand reset state", 32'(bus0.state), 32'd0);
            check("rand reset pcen", 32'(bus0.pcen), 32'd0);
            @(negedge clk);
            @(posedge clk);
            #2 reset = 1'b0;
            continue;
         end
         bus0.zero = 1'($urandom_range(0, 1));
         bus1.zero = 1'($urandom_range(0, 1));
         if (bus0.state == 4'd0) begin
            bus0.op = pick_op(); bus0.funct = pick_funct();
         end else if (bus0.state inside {4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11}) begin
            bus0.op = 6'($urandom); bus0.funct = 6'($urandom);
         end
         if (bus1.state == 4'd0) begin
            bus1.op = pick_op(); bus1.funct = pick_funct();
         end else if (bus1.state inside {4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11}) begin
            bus1.op = 6'($urandom); bus1.funct = 6'($urandom);
         end
      end

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
